// File: rtl/csd_shift_add_seq.sv
// Sequential multiplier y = x * c for a CSD-coded coefficient c.
// One shared add/sub unit; one cycle per nonzero digit, zero digits skipped.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | ready for a request; latches x, sanitized digits, error flag
//   S_RUN  | applies the lowest remaining nonzero digit each cycle
//   S_DONE | result valid, held until the consumer takes it
module csd_shift_add_seq #(
    parameter int WX = 8,
    parameter int W  = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WX-1:0] x,
    input  logic [2*W-1:0]       csd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WX+W:0] y,
    output logic                 err,
    output logic                 busy
);

    localparam int WY = WX + W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic signed [WY-1:0]  acc;
    logic signed [WX-1:0]  x_q;
    logic [2*W-1:0]        dig_q;
    logic                  err_q;

    logic [2*W-1:0]        csd_legal;
    logic                  csd_err;
    logic signed [WY-1:0]  x_ext;
    logic signed [WY-1:0]  term;
    logic                  term_neg;
    logic                  found;
    logic [2*W-1:0]        dig_clr;
    logic                  accept;

    assign x_ext  = {{(WY-WX){x_q[WX-1]}}, x_q};
    assign accept = in_valid && in_ready;
    assign y      = acc;
    assign err    = err_q;

    // Sanitize the incoming coefficient: illegal 10 digits become 0 and flag an error,
    // as do adjacent nonzero digits (legal arithmetic, but not canonical).
    always_comb begin
        csd_legal = csd;
        csd_err   = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (csd[2*i +: 2] == 2'b10) begin
                csd_legal[2*i +: 2] = 2'b00;
                csd_err             = 1'b1;
            end
        end
        for (int i = 0; i < W - 1; i++) begin
            if (csd[2*i +: 2] != 2'b00 && csd[2*i+2 +: 2] != 2'b00) begin
                csd_err = 1'b1;
            end
        end
    end

    // Pick the lowest nonzero digit: shifted operand, its sign, and the digits left after clearing it.
    always_comb begin
        dig_clr  = dig_q;
        term     = '0;
        term_neg = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!found && dig_q[2*i +: 2] != 2'b00) begin
                found               = 1'b1;
                term                = x_ext <<< i;
                term_neg            = dig_q[2*i+1];
                dig_clr[2*i +: 2]   = 2'b00;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = (csd_legal == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (dig_clr == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the request, then one shift-add/sub per remaining digit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc   <= '0;
            x_q   <= '0;
            dig_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            acc   <= '0;
            x_q   <= x;
            dig_q <= csd_legal;
            err_q <= csd_err;
        end else if (state == S_RUN) begin
            acc   <= term_neg ? (acc - term) : (acc + term);
            dig_q <= dig_clr;
        end
    end

endmodule

// File: tb/tb_csd_shift_add_seq.sv
// Self-checking bench for csd_shift_add_seq (WX=8, W=4, WY=13).
module tb_csd_shift_add_seq;

    logic               clk = 1'b0;
    logic               arst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [7:0]  x = '0;
    logic [7:0]         csd = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [12:0] y;
    logic               err;
    logic               busy;

    csd_shift_add_seq #(.WX(8), .W(4)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .csd       (csd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: coefficient value from the legal digits, error flag, and nonzero digit count.
    function automatic void model(input logic [7:0] xv, input logic [7:0] cv,
                                  output int py, output bit pe, output int pn);
        int c;
        logic [1:0] d;
        c  = 0;
        pe = 1'b0;
        pn = 0;
        for (int i = 0; i < 4; i++) begin
            d = cv[2*i +: 2];
            if (d == 2'b01) begin c = c + (1 << i); pn++; end
            else if (d == 2'b11) begin c = c - (1 << i); pn++; end
            else if (d == 2'b10) pe = 1'b1;
            if (i < 3 && d != 2'b00 && cv[2*i+2 +: 2] != 2'b00) pe = 1'b1;
        end
        py = int'($signed(xv)) * c;
    endfunction

    typedef struct {
        int y;
        bit err;
        int n;
        int acc_cyc;
    } exp_t;

    exp_t q[$];
    bit   front_seen = 1'b0;

    // Compare process: every falling edge, check handshake status and any valid result.
    always @(negedge clk) begin
        exp_t e;
        int   my;
        bit   me;
        int   mn;
        if (!arst_n) begin
            q.delete();
            front_seen = 1'b0;
        end else begin
            check("in_ready", int'(in_ready), int'(q.size() == 0));
            check("busy", int'(busy), int'(q.size() != 0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    if (!front_seen) begin
                        check("latency", cyc - (q[0].acc_cyc + 1), q[0].n);
                        front_seen = 1'b1;
                    end
                    check("y", int'($signed(y)), q[0].y);
                    check("err", int'(err), int'(q[0].err));
                    if (out_ready) begin
                        void'(q.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(x, csd, my, me, mn);
                e.y = my;
                e.err = me;
                e.n = mn;
                e.acc_cyc = cyc;
                q.push_back(e);
            end
        end
    end

    // Issue one request, wait for the result, hold it for 'hold' cycles with junk inputs, then take it.
    task automatic do_req(input logic [7:0] xv, input logic [7:0] cv, input int hold,
                          output int lat, output int ry, output bit re);
        int b;
        b = 0;
        while (!in_ready && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 50) check("in_ready_timeout", 0, 1);
        x = xv;
        csd = cv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            in_valid = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            csd = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) check("out_valid_timeout", 0, 1);
        ry = int'($signed(y));
        re = err;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            csd = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int ry;
        bit re;
        int my;
        bit me;
        int mn;

        // Reset state
        #2;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_y", int'($signed(y)), 0);
        check("rst_err", int'(err), 0);
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b1;
        @(posedge clk); #1;

        // Pin the model against hand-computed values
        model(8'd3, 8'b01000011, my, me, mn);
        check("model_c1_y", my, 21);
        check("model_c1_n", mn, 2);
        model(8'h80, 8'b01000000, my, me, mn);
        check("model_c3_y", my, -1024);
        model(8'd2, 8'b00001111, my, me, mn);
        check("model_c4_y", my, -6);
        check("model_c4_err", int'(me), 1);

        // Directed cases
        do_req(8'd3, 8'b01000011, 0, lat, ry, re);
        check("c1_lat", lat, 2);
        check("c1_y", ry, 21);
        check("c1_err", int'(re), 0);

        do_req(-8'sd5, 8'h00, 1, lat, ry, re);
        check("c2_lat", lat, 0);
        check("c2_y", ry, 0);
        check("c2_err", int'(re), 0);

        do_req(8'h80, 8'b01000000, 0, lat, ry, re);
        check("c3_lat", lat, 1);
        check("c3_y", ry, -1024);
        check("c3_err", int'(re), 0);

        do_req(8'd2, 8'b00001111, 2, lat, ry, re);
        check("c4a_lat", lat, 2);
        check("c4a_y", ry, -6);
        check("c4a_err", int'(re), 1);

        do_req(8'd2, 8'b00000010, 0, lat, ry, re);
        check("c4b_lat", lat, 0);
        check("c4b_y", ry, 0);
        check("c4b_err", int'(re), 1);

        // Backpressure, then a back-to-back request held across the handshake cycle
        x = 8'd3;
        csd = 8'b01000011;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", lat, 2);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            x = 8'd7;
            csd = 8'h01;
            @(posedge clk); #1;
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_y", int'($signed(y)), 21);
            check("bp_hold_err", int'(err), 0);
            check("bp_hold_in_ready", int'(in_ready), 0);
        end
        x = -8'sd7;
        csd = 8'h04;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_after_hs_in_ready", int'(in_ready), 1);
        check("bp_after_hs_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat", lat, 1);
        check("b2b_y", int'($signed(y)), -14);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of RUN
        x = 8'd3;
        csd = 8'b01000011;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_run_busy", int'(busy), 1);
        #2 arst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_y", int'($signed(y)), 0);
        check("mid_rst_err", int'(err), 0);
        @(posedge clk);
        #3 arst_n = 1'b1;
        @(posedge clk); #1;
        do_req(8'd3, 8'b01000011, 0, lat, ry, re);
        check("post_rst_lat", lat, 2);
        check("post_rst_y", ry, 21);

        // Randomized requests; the compare process checks each against the model
        for (int n = 0; n < 300; n++) begin
            do_req(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), lat, ry, re);
        end
        @(posedge clk); #1;
        check("final_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
